// File: rtl/dbg_move_pkg.sv
// Shared types for the debug-side data mover scheduler.
package dbg_move_pkg;

  localparam int DESC_AW = 32;

  typedef struct packed {
    logic [DESC_AW-1:0] src;
    logic [DESC_AW-1:0] dest;
    logic [DESC_AW-1:0] len;
    logic [7:0]         mask;
  } move_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_GUARD     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/dbg_move_fifo.sv
// Synchronous descriptor FIFO; pointers carry an extra wrap bit so full/empty
// are distinguished without a separate counter.
module dbg_move_fifo
  import dbg_move_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  move_desc_t             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output move_desc_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  move_desc_t    mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  // Pointer update; flush discards everything queued on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  // Descriptor storage, written only when the push is actually taken
  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/dbg_move_sched.sv
// Descriptor queue and sequencer: issues queued moves to the data mover one
// at a time, with a start pulse, done wait, timeout flag and completion count.
module dbg_move_sched
  import dbg_move_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [ADDR_WIDTH-1:0]   desc_src,
  input  logic [ADDR_WIDTH-1:0]   desc_dest,
  input  logic [ADDR_WIDTH-1:0]   desc_len,
  input  logic [7:0]              desc_mask,
  input  logic                    flush,
  input  logic                    clr_status,
  output logic [ADDR_WIDTH-1:0]   mv_src_addr,
  output logic [ADDR_WIDTH-1:0]   mv_dest_addr,
  output logic [ADDR_WIDTH-1:0]   mv_length,
  output logic [7:0]              mv_mask,
  output logic                    mv_en,
  input  logic                    mv_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  pending,
  output logic [15:0]             done_cnt,
  output logic                    timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_e  state;
  sched_state_e  state_next;
  move_desc_t    push_desc;
  move_desc_t    head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          launch;
  logic          null_done;
  logic          move_done;
  logic          tcnt_clr;
  logic          tcnt_inc;
  logic [TW-1:0] tcnt;

  // No push-through when full: a same-cycle pop does not free a slot
  assign desc_ready = !full && !flush;
  assign push       = desc_valid && desc_ready;
  assign push_desc  = '{src:  DESC_AW'(desc_src),
                        dest: DESC_AW'(desc_dest),
                        len:  DESC_AW'(desc_len),
                        mask: desc_mask};
  assign busy       = (state != ST_IDLE);

  dbg_move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_desc),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle controls; flush suppresses any pop from IDLE
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    launch     = 1'b0;
    null_done  = 1'b0;
    move_done  = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !flush) begin
          pop = 1'b1;
          if (head.len != '0) begin
            launch     = 1'b1;
            state_next = ST_LAUNCH;
          end else begin
            null_done = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        state_next = ST_GUARD;
      end
      ST_GUARD: begin
        tcnt_clr   = 1'b1;
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (mv_done) begin
          move_done  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Mover static inputs latch on launch and hold; enable is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_src_addr  <= '0;
      mv_dest_addr <= '0;
      mv_length    <= '0;
      mv_mask      <= '0;
      mv_en        <= 1'b0;
    end else begin
      mv_en <= launch;
      if (launch) begin
        mv_src_addr  <= ADDR_WIDTH'(head.src);
        mv_dest_addr <= ADDR_WIDTH'(head.dest);
        mv_length    <= ADDR_WIDTH'(head.len);
        mv_mask      <= head.mask;
      end
    end
  end

  // Wait-for-done cycle counter, saturating at the timeout limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tcnt_clr) begin
      tcnt <= '0;
    end else if (tcnt_inc && (tcnt != TW'(TIMEOUT))) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Sticky timeout flag, set as the counter reaches the limit; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (clr_status) begin
      timeout_err <= 1'b0;
    end else if (tcnt_inc && (tcnt == TW'(TIMEOUT - 1))) begin
      timeout_err <= 1'b1;
    end
  end

  // Completion counter for real and null moves; wraps, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (clr_status) begin
      done_cnt <= '0;
    end else if (null_done || move_done) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule
